// File: rtl/distortion_tap_source_pkg.sv
// Shared definitions for the distortion tap source: sizes, FSM states and the saturating adder.
package filter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int TAP_COUNT  = 5;
  localparam int FLUSH_LEN  = 4;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  // Adds two unsigned operands and clamps the result to 2^w-1.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                          input int unsigned w);
    logic [16:0] s;
    logic [16:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (17'd1 << w) - 17'd1;
    return (s > lim) ? lim[15:0] : s[15:0];
  endfunction

endpackage

// File: rtl/distortion_tap_source_if.sv
// Sample-in / tap-window-out bundle between a sample producer and the distortion tap source.
interface distortion_tap_source_if #(parameter int DATA_W = 8);
  logic              in_valid;
  logic [DATA_W-1:0] in_sample;
  logic              in_ready;
  logic              flush_req;
  logic [DATA_W-1:0] tap0;
  logic [DATA_W-1:0] tap1;
  logic [DATA_W-1:0] tap2;
  logic [DATA_W-1:0] tap3;
  logic [DATA_W-1:0] tap4;
  logic              taps_valid;
  logic              busy;

  modport master (output in_valid, in_sample, flush_req,
                  input  in_ready, tap0, tap1, tap2, tap3, tap4, taps_valid, busy);
  modport slave  (input  in_valid, in_sample, flush_req,
                  output in_ready, tap0, tap1, tap2, tap3, tap4, taps_valid, busy);
endinterface

// File: rtl/distortion_tap_source_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as the noise source; only exists when NOISE_EN is defined.
`ifdef NOISE_EN
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  logic [7:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= seed;
    end else if (adv) begin
      r_q <= {r_q[6:0], r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3]};
    end
  end

  assign q = r_q;
endmodule
`endif

// File: rtl/distortion_tap_source.sv
// Distorting 5-tap delay-line producer: echo (+ LFSR noise when NOISE_EN is defined), fill/run/flush FSM.
module distortion_tap_source
  import filter_pkg::*;
#(
  parameter int         DATA_W     = DATA_W_DEF,
  parameter int         ECHO_SHIFT = 1,
  parameter int         NOISE_BITS = 2,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  distortion_tap_source_if.slave bus
);
  localparam logic [2:0] FULL = 3'(TAP_COUNT);

  if (LFSR_SEED == 8'h00 || NOISE_BITS < 1 || NOISE_BITS > 8) begin : g_bad_cfg
    $error("distortion_tap_source: LFSR_SEED must be nonzero and NOISE_BITS in 1..8");
  end

  state_t            r_state;
  logic [DATA_W-1:0] r_tap [TAP_COUNT];
  logic [DATA_W-1:0] r_prev_x;
  logic [2:0]        r_fill_cnt;
  logic [1:0]        r_flush_cnt;
  logic              r_full_shift_p0;
  logic              r_taps_valid_p1;

  logic              w_ready;
  logic              w_accept;
  logic              w_clear;
  logic              w_take;
  logic              w_zero_shift;
  logic [2:0]        w_fill_next;
  logic [15:0]       w_noise;
  logic [15:0]       w_echo;
  logic [15:0]       w_sum;
  logic [DATA_W-1:0] w_d;
  logic [DATA_W-1:0] w_shift_val;

  assign w_ready      = (r_state != FLUSH);
  assign w_accept     = bus.in_valid & w_ready;
  // A flush during FILL wins over a same-cycle sample: the sample is handshaken but dropped.
  assign w_clear      = (r_state == FILL) & bus.flush_req;
  assign w_take       = w_accept & ~w_clear;
  assign w_zero_shift = (r_state == FLUSH);
  assign w_fill_next  = (r_fill_cnt == FULL) ? FULL : r_fill_cnt + 3'd1;

`ifdef NOISE_EN
  logic [7:0] w_lfsr;
  lfsr8 u_lfsr (.clk(clk), .rst(rst), .adv(w_take), .seed(LFSR_SEED), .q(w_lfsr));
  assign w_noise = 16'(w_lfsr[NOISE_BITS-1:0]);
`else
  assign w_noise = '0;
`endif

  assign w_echo      = 16'(r_prev_x >> ECHO_SHIFT);
  assign w_sum       = sat_add(16'(bus.in_sample), w_echo + w_noise, DATA_W);
  assign w_d         = w_sum[DATA_W-1:0];
  assign w_shift_val = w_zero_shift ? '0 : w_d;

  // Stage p0: delay line update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAP_COUNT; i++) r_tap[i] <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < TAP_COUNT; i++) r_tap[i] <= '0;
    end else if (w_take | w_zero_shift) begin
      r_tap[0] <= w_shift_val;
      for (int i = 1; i < TAP_COUNT; i++) r_tap[i] <= r_tap[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_prev_x        <= '0;
      r_fill_cnt      <= '0;
      r_flush_cnt     <= '0;
      r_full_shift_p0 <= 1'b0;
      r_taps_valid_p1 <= 1'b0;
    end else begin
      r_full_shift_p0 <= 1'b0;
      r_taps_valid_p1 <= r_full_shift_p0;
      if (w_take) begin
        r_prev_x        <= bus.in_sample;
        r_fill_cnt      <= w_fill_next;
        r_full_shift_p0 <= (w_fill_next == FULL);
      end
      case (r_state)
        IDLE: if (w_take) r_state <= FILL;
        FILL: begin
          if (w_clear) begin
            r_state    <= IDLE;
            r_prev_x   <= '0;
            r_fill_cnt <= '0;
          end else if (w_take && w_fill_next == FULL) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.flush_req) begin
            r_state     <= FLUSH;
            r_flush_cnt <= '0;
          end
        end
        FLUSH: begin
          r_full_shift_p0 <= 1'b1;
          r_flush_cnt     <= r_flush_cnt + 2'd1;
          if (r_flush_cnt == 2'(FLUSH_LEN - 1)) begin
            r_state    <= IDLE;
            r_fill_cnt <= '0;
            r_prev_x   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage p1: registered window strobe and outputs
  assign bus.in_ready   = w_ready;
  assign bus.tap0       = r_tap[0];
  assign bus.tap1       = r_tap[1];
  assign bus.tap2       = r_tap[2];
  assign bus.tap3       = r_tap[3];
  assign bus.tap4       = r_tap[4];
  assign bus.taps_valid = r_taps_valid_p1;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_distortion_tap_source.sv
// Randomized and directed bench for distortion_tap_source against a window-level reference model.
module tb_distortion_tap_source;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  distortion_tap_source_if #(.DATA_W(8)) bus ();

  distortion_tap_source #(
    .DATA_W(8), .ECHO_SHIFT(1), .NOISE_BITS(2), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the window as a 5-entry array, a fill count (0 = idle),
  // and the number of drain cycles still owed.
  int m_tap [5];
  int m_prev, m_count, m_flush_left, m_pend, m_tv, m_lfsr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int dut_tap(input int i);
    case (i)
      0: return int'(bus.tap0);
      1: return int'(bus.tap1);
      2: return int'(bus.tap2);
      3: return int'(bus.tap3);
      default: return int'(bus.tap4);
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_tap[i]) m_tap[i] = 0;
    m_prev = 0; m_count = 0; m_flush_left = 0; m_pend = 0; m_tv = 0; m_lfsr = 'hA5;
  endtask

  task automatic model_push(input int d);
    for (int i = 4; i > 0; i--) m_tap[i] = m_tap[i-1];
    m_tap[0] = d;
  endtask

  task automatic model_edge(input int v, input int s, input int f);
    int d;
    m_tv = m_pend;
    m_pend = 0;
    if (m_flush_left > 0) begin
      model_push(0);
      m_flush_left--;
      m_pend = 1;
      if (m_flush_left == 0) begin m_count = 0; m_prev = 0; end
    end else if (m_count > 0 && m_count < 5 && f != 0) begin
      foreach (m_tap[i]) m_tap[i] = 0;
      m_count = 0;
      m_prev = 0;
    end else begin
      if (v != 0) begin
        d = s + m_prev / 2;
`ifdef NOISE_EN
        d = d + (m_lfsr % 4);
        m_lfsr = ((m_lfsr * 2) % 256) +
                 (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
`endif
        if (d > 255) d = 255;
        model_push(d);
        m_prev = s;
        if (m_count < 5) m_count++;
        if (m_count == 5) m_pend = 1;
      end
      if (m_count == 5 && f != 0) m_flush_left = 4;
    end
  endtask

  task automatic check_outputs(input string where);
    for (int i = 0; i < 5; i++) check($sformatf("%s tap%0d", where, i), dut_tap(i), m_tap[i]);
    check({where, " taps_valid"}, int'(bus.taps_valid), m_tv);
    check({where, " busy"}, int'(bus.busy), (m_count > 0 || m_flush_left > 0) ? 1 : 0);
    check({where, " in_ready"}, int'(bus.in_ready), (m_flush_left == 0) ? 1 : 0);
  endtask

  task automatic step(input int v, input int s, input int f, input string where);
    bus.in_valid  = v[0];
    bus.in_sample = s[7:0];
    bus.flush_req = f[0];
    @(posedge clk);
    #1;
    model_edge(v, s, f);
    check_outputs(where);
    bus.in_valid  = 1'b0;
    bus.flush_req = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.flush_req = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_ramp(input string where);
    for (int i = 0; i < 5; i++) step(1, 10 * (i + 1), 0, where);
    check({where, " tap0"}, int'(bus.tap0), 70);
    check({where, " tap1"}, int'(bus.tap1), 55);
    check({where, " tap2"}, int'(bus.tap2), 40);
    check({where, " tap3"}, int'(bus.tap3), 25);
    check({where, " tap4"}, int'(bus.tap4), 10);
    check({where, " no early strobe"}, int'(bus.taps_valid), 0);
    step(0, 0, 0, where);
    check({where, " strobe"}, int'(bus.taps_valid), 1);
    step(0, 0, 0, where);
    check({where, " strobe single"}, int'(bus.taps_valid), 0);
  endtask

  initial begin
    int ready_lo, strobes, v, s, f;
    rst = 1'b0;
    do_reset();

`ifndef NOISE_EN
    run_ramp("ramp");

    step(1, 8, 1, "drain");
    ready_lo = bus.in_ready ? 0 : 1;
    strobes  = int'(bus.taps_valid);
    for (int j = 0; j < 5; j++) begin
      step(0, 0, 0, "drain");
      if (!bus.in_ready) ready_lo++;
      strobes += int'(bus.taps_valid);
      if (j == 3) begin
        check("drain tap0", int'(bus.tap0), 0);
        check("drain tap3", int'(bus.tap3), 0);
        check("drain tap4", int'(bus.tap4), 33);
        check("drain idle", int'(bus.busy), 0);
      end
    end
    check("drain ready low cycles", ready_lo, 4);
    check("drain strobes (sample + 4 zeros)", strobes, 5);

    do_reset();
    step(1, 200, 0, "sat");
    step(1, 200, 0, "sat");
    check("sat tap0", int'(bus.tap0), 255);
    check("sat tap1", int'(bus.tap1), 200);

    do_reset();
    for (int i = 1; i <= 3; i++) step(1, i * 7, 0, "fillflush");
    step(1, 99, 1, "fillflush");
    check("fillflush tap0", int'(bus.tap0), 0);
    check("fillflush tap2", int'(bus.tap2), 0);
    check("fillflush idle", int'(bus.busy), 0);
    step(1, 5, 0, "fillflush");
    check("fillflush restart tap0", int'(bus.tap0), 5);

    do_reset();
    for (int i = 0; i < 5; i++) step(1, 10 * (i + 1), 0, "rstflush");
    step(0, 0, 1, "rstflush");
    step(0, 0, 0, "rstflush");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async rst");
    check("async rst tap4", int'(bus.tap4), 0);
    check("async rst ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    run_ramp("post rst ramp");
`else
    step(1, 0, 0, "noise");
    check("noise first d", int'(bus.tap0), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, "noise");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "noise hold");
    step(1, 0, 0, "noise resume");
`endif

    do_reset();
    for (int c = 0; c < 800; c++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      s = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(180, 255));
      f = ($urandom_range(0, 19) == 0) ? 1 : 0;
      step(v, s, f, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
